// File: rtl/shift_sequencer_4b_if.sv
// Handshake/data bundle between a shift requester and shift_sequencer_4b.
//   start : request a new shift operation (sampled only while the sequencer is idle)
//   in    : operand, captured with start
//   amt   : number of 1-position left shifts, captured with start
//   fill  : bit shifted into the LSB on every step, captured with start
//   out   : working/result register
//   cout  : most recent bit shifted out of the MSB
//   busy  : high while shifting
//   done  : one-cycle pulse when out/cout hold the final result
// master = requester side, slave = sequencer side.
interface shift_sequencer_4b_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
);
    logic             start;
    logic [WIDTH-1:0] in;
    logic [AMT_W-1:0] amt;
    logic             fill;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             busy;
    logic             done;

    modport master (
        output start, in, amt, fill,
        input  out, cout, busy, done
    );

    modport slave (
        input  start, in, amt, fill,
        output out, cout, busy, done
    );
endinterface

// File: rtl/shift_sequencer_4b.sv
// Multi-cycle left-shift controller. A request captures an operand, a shift
// amount and a fill bit, then a single 1-position shift stage is applied once
// per clock until the amount is exhausted. Variable-distance shifts therefore
// need no barrel shifter.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset (aborts any operation, no done pulse)
//   bus : shift_sequencer_4b_if.slave (start/in/amt/fill in; out/cout/busy/done out)
module shift_sequencer_4b #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_sequencer_4b_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] out_reg,   out_next;
    logic             cout_reg,  cout_next;
    logic             fill_reg,  fill_next;
    logic [AMT_W-1:0] cnt_reg,   cnt_next;

    // One-position left shift stage with the captured fill bit entering the LSB.
    logic [WIDTH-1:0] shifted;
    assign shifted[0] = fill_reg;
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
        assign shifted[gi] = out_reg[gi-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            out_reg   <= '0;
            cout_reg  <= 1'b0;
            fill_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            cout_reg  <= cout_next;
            fill_reg  <= fill_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        out_next   = out_reg;
        cout_next  = cout_reg;
        fill_next  = fill_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    out_next  = bus.in;
                    cout_next = 1'b0;
                    fill_next = bus.fill;
                    cnt_next  = bus.amt;
                    // A zero-length shift skips straight to the result cycle.
                    state_next = (bus.amt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                out_next  = shifted;
                cout_next = out_reg[WIDTH-1];
                cnt_next  = cnt_reg - AMT_W'(1);
                // Leaving at cnt==1 means the counter never wraps through zero.
                if (cnt_reg == AMT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here; it must be re-presented in idle.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.out  = out_reg;
    assign bus.cout = cout_reg;
    assign bus.busy = (state_reg == ST_SHIFT);
    assign bus.done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer_4b.sv
module tb_shift_sequencer_4b;

    logic clk;
    logic rst;

    shift_sequencer_4b_if #(.WIDTH(4), .AMT_W(3)) bus ();

    shift_sequencer_4b #(.WIDTH(4), .AMT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fails;

    typedef struct {
        logic [3:0] in;
        logic [2:0] amt;
        logic       fill;
        logic [3:0] exp_out;
        logic       exp_cout;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Launch one operation, scramble the live inputs after acceptance, and
    // check latency, busy length, result and result hold.
    task automatic run_op(input string tag, input logic [3:0] in_v, input logic [2:0] amt_v,
                          input logic fill_v, input logic [3:0] exp_out, input logic exp_cout);
        int  k;
        int  busy_n;
        bit  seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = in_v;
        bus.amt   = amt_v;
        bus.fill  = fill_v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.in    = ~in_v;
        bus.amt   = ~amt_v;
        bus.fill  = ~fill_v;
        k = 0;
        busy_n = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (bus.busy) busy_n++;
            if (bus.done) seen = 1'b1;
        end
        check({tag, " latency"}, k, 32'(amt_v) + 1);
        check({tag, " busy_cycles"}, busy_n, 32'(amt_v));
        check({tag, " out"}, bus.out, exp_out);
        check({tag, " cout"}, bus.cout, exp_cout);
        @(negedge clk);
        check({tag, " done_one_cycle"}, bus.done, 1'b0);
        check({tag, " out_hold"}, bus.out, exp_out);
        $display("op %s: in=%b amt=%0d fill=%b -> out=%b cout=%b latency=%0d", tag, in_v, amt_v, fill_v, bus.out, bus.cout, k);
    endtask

    initial begin
        int done_n;
        int done_k;

        n_checks = 0;
        n_fails  = 0;

        vecs[0] = '{4'b1011, 3'd1, 1'b0, 4'b0110, 1'b1};
        vecs[1] = '{4'b1011, 3'd3, 1'b1, 4'b1111, 1'b1};
        vecs[2] = '{4'b1011, 3'd0, 1'b1, 4'b1011, 1'b0};
        vecs[3] = '{4'b1001, 3'd6, 1'b0, 4'b0000, 1'b0};
        vecs[4] = '{4'b1001, 3'd4, 1'b0, 4'b0000, 1'b1};
        vecs[5] = '{4'b0110, 3'd2, 1'b1, 4'b1011, 1'b1};
        vecs[6] = '{4'b1010, 3'd7, 1'b1, 4'b1111, 1'b1};
        vecs[7] = '{4'b0101, 3'd5, 1'b1, 4'b1111, 1'b1};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.in    = 4'b0000;
        bus.amt   = 3'd0;
        bus.fill  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset out", bus.out, 4'b0000);
        check("reset cout", bus.cout, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        $display("reset: out=%b cout=%b busy=%b done=%b", bus.out, bus.cout, bus.busy, bus.done);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].in, vecs[i].amt, vecs[i].fill,
                   vecs[i].exp_out, vecs[i].exp_cout);
        end

        // Intermediate values of a 3-step shift.
        @(negedge clk);
        bus.start = 1'b1; bus.in = 4'b1011; bus.amt = 3'd3; bus.fill = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("step1 loaded", bus.out, 4'b1011);
        @(negedge clk);
        check("step2 out", bus.out, 4'b0111);
        check("step2 cout", bus.cout, 1'b1);
        @(negedge clk);
        check("step3 out", bus.out, 4'b1111);
        check("step3 cout", bus.cout, 1'b0);
        @(negedge clk);
        check("step4 out", bus.out, 4'b1111);
        check("step4 done", bus.done, 1'b1);
        $display("steps: final out=%b cout=%b done=%b", bus.out, bus.cout, bus.done);
        @(negedge clk);

        // Extra starts during SHIFT and DONE must be ignored.
        bus.start = 1'b1; bus.in = 4'b0001; bus.amt = 3'd5; bus.fill = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        done_n = 0;
        done_k = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.done) begin
                done_n++;
                if (done_k == 0) done_k = k;
            end
            if (k == 2) begin
                bus.start = 1'b1; bus.in = 4'b1111; bus.amt = 3'd1;
            end else if (k == 3) begin
                bus.start = 1'b0;
            end else if (k == 6) begin
                bus.start = 1'b1;
            end else if (k == 7) begin
                bus.start = 1'b0;
            end
        end
        check("ignore done_at", done_k, 6);
        check("ignore done_count", done_n, 1);
        check("ignore out", bus.out, 4'b0000);
        check("ignore cout", bus.cout, 1'b0);
        check("ignore idle_busy", bus.busy, 1'b0);
        $display("ignore: done_at=%0d done_count=%0d out=%b cout=%b", done_k, done_n, bus.out, bus.cout);

        // Reset on the 3rd SHIFT cycle aborts without a done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.in = 4'b1111; bus.amt = 3'd7; bus.fill = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort out", bus.out, 4'b0000);
        check("abort cout", bus.cout, 1'b0);
        check("abort busy", bus.busy, 1'b0);
        check("abort done", bus.done, 1'b0);
        rst = 1'b0;
        done_n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done) done_n++;
        end
        check("abort no_done", done_n, 0);
        $display("abort: out=%b busy=%b done_after=%0d", bus.out, bus.busy, done_n);
        run_op("post_abort", 4'b1100, 3'd2, 1'b1, 4'b0011, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/shift_sequencer_4b.md
Name: shift_sequencer_4b

Overview:
- Multi-cycle left-shift controller.
- Accepts a 4-bit operand, a shift amount and a fill bit, then sequences a 1-position left-shift stage once per clock until the requested amount is reached.
- Reports the result, the last bit shifted out, and a one-cycle done pulse.
- Sits between control logic and the shift datapath, so variable-distance shifts need no barrel shifter.

Parameters:
- WIDTH, 4, operand/result width in bits.
- AMT_W, 3, width of the shift-amount field (amounts 0..2^AMT_W-1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new shift operation; sampled only in IDLE.
- in  input  WIDTH  operand, captured when start is accepted.
- amt  input  AMT_W  number of 1-position shifts, captured with start.
- fill  input  1  bit shifted into LSB each step, captured with start.
- out  output  WIDTH  working/result register.
- cout  output  1  most recent bit shifted out of MSB.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when result is valid.

Behaviour:
- Reset (rst=1 at rising edge): state=IDLE; out=0, cout=0, busy=0, done=0, counter=0. Reset has priority over all other inputs, including mid-operation; an aborted operation produces no done pulse.
- States: IDLE, SHIFT, DONE. Encoding is free.
- IDLE:
  - start=1: out<=in, cout<=0, fill_r<=fill, cnt<=amt.
  - amt!=0: go to SHIFT.
  - amt==0: go to DONE.
  - start=0: hold everything.
- SHIFT, each cycle:
  - out<={out[WIDTH-2:0], fill_r}, cout<=out[WIDTH-1], cnt<=cnt-1.
  - When cnt==1 (the last shift), go to DONE.
  - busy=1 throughout SHIFT.
- DONE:
  - done=1 for exactly this one cycle, busy=0, then unconditionally return to IDLE.
  - start during DONE is ignored; it must be re-presented in IDLE.
- start while in SHIFT or DONE: ignored, with no effect on the operation in flight.
- Latency: done goes high amt+1 cycles after the cycle in which start is sampled in IDLE. amt=0 gives 1 cycle.
- Minimum spacing between accepted starts is amt+2 cycles.
- Result hold: out and cout stay stable from done until the next accepted start.
- amt >= WIDTH is legal:
  - All operand bits are shifted out and out becomes all fill_r.
  - cout is the last bit shifted out, which is fill_r when amt > WIDTH and in[0] when amt == WIDTH.
- The in, amt and fill inputs may change freely after start is accepted. Only the captured copies are used.
- cout=0 when amt=0.
- No arithmetic beyond the cnt decrement. cnt never wraps because the FSM leaves SHIFT at cnt==1.

Test Plan:
- Reset, then in=4'b1011, amt=1, fill=0, start pulse:
  - busy=1 for 1 cycle.
  - done=1 two cycles after start.
  - out=4'b0110, cout=1.
- in=4'b1011, amt=3, fill=1:
  - Intermediate out values 0111, 1111, 1111.
  - Final out=4'b1111, cout=1.
  - done 4 cycles after start, busy high 3 cycles.
- in=4'b1011, amt=0, fill=1:
  - No SHIFT cycles.
  - done 1 cycle after start.
  - out=4'b1011, cout=0.
- in=4'b1001, amt=6, fill=0:
  - out=4'b0000, cout=0.
  - done 7 cycles after start.
  - Repeat with amt=4: out=0000, cout=1.
- Start in=4'b0001, amt=5, then pulse start with in=4'b1111, amt=1 during the 2nd SHIFT cycle and during DONE:
  - Both extra starts are ignored.
  - Final out=4'b0000, cout=0, single done pulse.
- Start in=4'b1111, amt=7, assert rst on the 3rd SHIFT cycle:
  - Next cycle state is IDLE with out=0, cout=0, busy=0.
  - No done pulse.
  - A fresh start then completes normally.
